// File: rtl/case_7_sdiv_8s_seq.sv
// Multi-cycle signed divider (radix-2 restoring, one quotient bit per clock).
// Quotient truncates toward zero and the remainder carries the dividend's sign.
//
//   state | meaning
//   IDLE  | waiting for start; ready=1
//   CALC  | one restoring iteration per cycle, din0_WIDTH cycles
//   FIX   | apply signs and special cases, register results
//   DONE  | done pulse; ready=1, a start here begins the next operation
module case_7_sdiv_8s_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  start,
    output logic                  ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  done,
    output logic [din0_WIDTH-1:0] dout_q,
    output logic [din1_WIDTH-1:0] dout_r,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int CW = $clog2(W0 + 1);
    localparam int unused_id = ID;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [W0-1:0] dvd;      // dividend bits shift out of the top, quotient bits in at the bottom
    logic [W1:0]   rem;
    logic [W1:0]   dsr;
    logic          sgn0, sgn1, dz_p, ov_p;

    logic          accept;
    logic [W0-1:0] mag0;
    logic [W1:0]   din1_ext, mag1;
    logic          dz_c, ov_c;
    logic [W1:0]   pr, diff;
    logic          take;
    logic [W0-1:0] q_neg;
    logic [W1-1:0] r_mag, r_neg;

    assign accept = start & ready;

    always_comb begin
        mag0     = din0[W0-1] ? (W0'(0) - din0) : din0;
        din1_ext = {din1[W1-1], din1};
        mag1     = din1[W1-1] ? ((W1+1)'(0) - din1_ext) : din1_ext;
        dz_c     = (din1 == '0);
        ov_c     = (din0 == {1'b1, {(W0-1){1'b0}}}) && (din1 == '1);
    end

    always_comb begin
        pr    = {rem[W1-1:0], dvd[W0-1]};
        diff  = pr - dsr;
        take  = (pr >= dsr);
        q_neg = W0'(0) - dvd;
        r_mag = rem[W1-1:0];
        r_neg = W1'(0) - r_mag;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE) || (state == DONE);
        done  = (state == DONE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt         <= '0;
            dvd         <= '0;
            rem         <= '0;
            dsr         <= '0;
            sgn0        <= 1'b0;
            sgn1        <= 1'b0;
            dz_p        <= 1'b0;
            ov_p        <= 1'b0;
            dout_q      <= '0;
            dout_r      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            cnt  <= CW'(W0);
            dvd  <= mag0;
            rem  <= '0;
            dsr  <= mag1;
            sgn0 <= din0[W0-1];
            sgn1 <= din1[W1-1];
            dz_p <= dz_c;
            ov_p <= ov_c;
        end else if (state == CALC) begin
            dvd <= {dvd[W0-2:0], take};
            rem <= take ? diff : pr;
            cnt <= cnt - CW'(1);
        end else if (state == FIX) begin
            // Overflow needs no special path: negating the magnitude of min wraps back to min.
            if (dz_p) begin
                dout_q <= '1;
                dout_r <= '0;
            end else begin
                dout_q <= (sgn0 ^ sgn1) ? q_neg : dvd;
                dout_r <= sgn0 ? r_neg : r_mag;
            end
            div_by_zero <= dz_p;
            overflow    <= ov_p;
        end
    end

endmodule
